// File: rtl/if_pcgen.sv
// Fetch-stage PC generator: picks the next fetch PC (reset / redirect / BTB / PC+4),
// runs a single-outstanding req/ack fetch and hands {pc, inst, prediction} to ID.
module if_pcgen #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000,
   parameter int          TAG_W    = 10
) (
   input  logic             cpu_clk_50M,
   input  logic             cpu_rst_n,
   output logic [TAG_W-1:0] pc_tag,
   input  logic             btb_jump_ena,
   input  logic [31:0]      btb_prepc,
   input  logic             redirect_valid,
   input  logic [31:0]      redirect_pc,
   output logic             if_req,
   output logic [31:0]      if_addr,
   input  logic             if_ack,
   input  logic [31:0]      if_rdata,
   input  logic             stall,
   output logic             id_valid,
   output logic [31:0]      id_pc,
   output logic [31:0]      id_inst,
   output logic             id_pred_taken,
   output logic [31:0]      id_pred_pc,
   output logic [1:0]       dbg_state
);

   // Handshakes:
   //   fetch side: if_req is the valid, if_ack the ready/response. Once if_req rises,
   //     if_addr is held and if_req stays high until the cycle if_ack=1; exactly one
   //     response per request, so a killed request is still waited out in S_DISCARD.
   //   ID side: id_valid is the valid, !stall the ready. A transfer happens on any edge
   //     with id_valid=1 and stall=0; while stalled every id_* output is held.
   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_REQ     = 2'd1,
      S_HOLD    = 2'd2,
      S_DISCARD = 2'd3
   } state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        taken;
      logic [31:0] pred_pc;
   } pkt_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] kill_addr_q, kill_addr_d;
   pkt_t        out_q, out_d;
   logic        out_valid_q, out_valid_d;
   pkt_t        skid_q, skid_d;
   logic        skid_valid_q, skid_valid_d;

   logic [31:0] redir_pc;
   logic [31:0] pred_next;
   pkt_t        fetch_pkt;
   logic        consume;
   logic        can_accept;
   logic        redirect_pc_unused;

   assign redir_pc           = {redirect_pc[31:2], 2'b00};
   assign redirect_pc_unused = ^redirect_pc[1:0];
   assign pc_tag             = pc_q[TAG_W+1:2];

   // Prediction is taken for the PC being acked; wraps naturally at 2^32.
   assign pred_next = btb_jump_ena ? btb_prepc : (pc_q + 32'd4);

   always_comb begin
      fetch_pkt.pc      = pc_q;
      fetch_pkt.inst    = if_rdata;
      fetch_pkt.taken   = btb_jump_ena;
      fetch_pkt.pred_pc = btb_jump_ena ? btb_prepc : 32'h0;
   end

   assign consume    = out_valid_q && !stall;
   assign can_accept = !out_valid_q || !stall;

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      kill_addr_d  = kill_addr_q;
      out_d        = out_q;
      out_valid_d  = out_valid_q;
      skid_d       = skid_q;
      skid_valid_d = skid_valid_q;

      if (consume) begin
         out_valid_d = 1'b0;
      end

      case (state_q)
         S_IDLE: begin
            if (redirect_valid) begin
               pc_d    = redir_pc;
               state_d = S_REQ;
            end else if (can_accept) begin
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            if (redirect_valid) begin
               pc_d = redir_pc;
               if (!if_ack) begin
                  kill_addr_d = pc_q;
                  state_d     = S_DISCARD;
               end
            end else if (if_ack) begin
               pc_d = pred_next;
               if (can_accept) begin
                  out_d       = fetch_pkt;
                  out_valid_d = 1'b1;
               end else begin
                  skid_d       = fetch_pkt;
                  skid_valid_d = 1'b1;
                  state_d      = S_HOLD;
               end
            end
         end
         S_HOLD: begin
            if (redirect_valid) begin
               pc_d    = redir_pc;
               state_d = S_REQ;
            end else if (!stall) begin
               out_d        = skid_q;
               out_valid_d  = skid_valid_q;
               skid_valid_d = 1'b0;
               state_d      = S_REQ;
            end
         end
         S_DISCARD: begin
            // The response to the killed address is swallowed here.
            if (redirect_valid) begin
               pc_d = redir_pc;
            end
            if (if_ack) begin
               state_d = S_REQ;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (redirect_valid) begin
         out_valid_d  = 1'b0;
         skid_valid_d = 1'b0;
         skid_d       = '0;
      end
   end

   always_ff @(posedge cpu_clk_50M) begin
      if (!cpu_rst_n) begin
         state_q      <= S_IDLE;
         pc_q         <= RESET_PC;
         kill_addr_q  <= 32'h0;
         out_q        <= '0;
         out_valid_q  <= 1'b0;
         skid_q       <= '0;
         skid_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         kill_addr_q  <= kill_addr_d;
         out_q        <= out_d;
         out_valid_q  <= out_valid_d;
         skid_q       <= skid_d;
         skid_valid_q <= skid_valid_d;
      end
   end

   always_comb begin
      if_addr = 32'h0;
      case (state_q)
         S_REQ:     if_addr = pc_q;
         S_DISCARD: if_addr = kill_addr_q;
         default:   if_addr = 32'h0;
      endcase
   end

   assign if_req        = (state_q == S_REQ) || (state_q == S_DISCARD);
   assign id_valid      = out_valid_q;
   assign id_pc         = out_q.pc;
   assign id_inst       = out_q.inst;
   assign id_pred_taken = out_q.taken;
   assign id_pred_pc    = out_q.pred_pc;
   assign dbg_state     = state_q;

endmodule

// File: tb/tb_if_pcgen.sv
// Bench for if_pcgen: the bench plays memory/BTB/EX/ID, expected ID transfers are
// queued when their fetch is acked and checked when ID takes them.
module tb_if_pcgen;
  localparam logic [1:0] ST_IDLE = 2'd0, ST_REQ = 2'd1, ST_HOLD = 2'd2, ST_DISCARD = 2'd3;

  logic        clk;
  logic        cpu_rst_n;
  logic [9:0]  pc_tag;
  logic        btb_jump_ena;
  logic [31:0] btb_prepc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        stall;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_pred_taken;
  logic [31:0] id_pred_pc;
  logic [1:0]  dbg_state;

  int n_checks;
  int n_fail;
  logic [96:0] exp_q[$];
  logic [31:0] pc_e;

  if_pcgen #(.RESET_PC(32'h8000_0000), .TAG_W(10)) dut (
    .cpu_clk_50M(clk), .cpu_rst_n(cpu_rst_n), .pc_tag(pc_tag),
    .btb_jump_ena(btb_jump_ena), .btb_prepc(btb_prepc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .stall(stall), .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst),
    .id_pred_taken(id_pred_taken), .id_pred_pc(id_pred_pc), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard: an ID transfer happens at the next rising edge
  always @(negedge clk) begin
    logic [96:0] e;
    if (cpu_rst_n && id_valid && !stall) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected got pc=%h inst=%h, no transfer expected", id_pc, id_inst);
      end else begin
        e = exp_q.pop_front();
        if ({id_pc, id_inst, id_pred_taken, id_pred_pc} !== e) begin
          n_fail++;
          $display("FAIL sb_id got pc=%h inst=%h tk=%b ppc=%h exp pc=%h inst=%h tk=%b ppc=%h",
                   id_pc, id_inst, id_pred_taken, id_pred_pc, e[96:65], e[64:33], e[32], e[31:0]);
        end
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ack, input logic [31:0] rdata, input logic jmp,
                       input logic [31:0] ppc, input logic rv, input logic [31:0] rpc,
                       input logic stl);
    if_ack = ack; if_rdata = rdata; btb_jump_ena = jmp; btb_prepc = ppc;
    redirect_valid = rv; redirect_pc = rpc; stall = stl;
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] inst, input logic tk,
                      input logic [31:0] ppc);
    exp_q.push_back({pc, inst, tk, tk ? ppc : 32'h0});
  endtask

  task automatic test_reset();
    cpu_rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (3) step();
    n_checks++; if (if_req !== 1'b0) begin n_fail++; $display("FAIL rst_if_req got %b exp 0", if_req); end
    n_checks++; if (if_addr !== 32'h0) begin n_fail++; $display("FAIL rst_if_addr got %h exp 0", if_addr); end
    n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL rst_id_valid got %b exp 0", id_valid); end
    n_checks++; if ({id_pc, id_inst, id_pred_taken, id_pred_pc} !== 97'h0) begin
      n_fail++; $display("FAIL rst_id_fields got pc=%h inst=%h tk=%b ppc=%h exp all 0", id_pc, id_inst, id_pred_taken, id_pred_pc); end
    n_checks++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL rst_state got %0d exp %0d", dbg_state, ST_IDLE); end
    n_checks++; if (pc_tag !== 10'h0) begin n_fail++; $display("FAIL rst_pc_tag got %h exp 0", pc_tag); end
  endtask

  task automatic test_free_run();
    logic [31:0] inst;
    cpu_rst_n = 1'b1;
    step();
    pc_e = 32'h8000_0000;
    for (int i = 0; i < 6; i++) begin
      n_checks++; if (if_req !== 1'b1 || if_addr !== pc_e) begin
        n_fail++; $display("FAIL free_if_addr[%0d] got req=%b addr=%h exp req=1 addr=%h", i, if_req, if_addr, pc_e); end
      n_checks++; if (pc_tag !== pc_e[11:2]) begin
        n_fail++; $display("FAIL free_pc_tag[%0d] got %h exp %h", i, pc_tag, pc_e[11:2]); end
      if (i > 0) begin
        n_checks++; if (id_valid !== 1'b1 || id_pc !== pc_e - 32'd4) begin
          n_fail++; $display("FAIL free_id_lag[%0d] got v=%b pc=%h exp v=1 pc=%h", i, id_valid, id_pc, pc_e - 32'd4); end
      end
      inst = $urandom();
      drive(1, inst, 0, 32'h0, 0, 0, 0);
      push(pc_e, inst, 0, 32'h0);
      step();
      pc_e = pc_e + 32'd4;
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
  endtask

  task automatic test_btb_hit();
    logic [31:0] inst;
    inst = $urandom();
    drive(1, inst, 1, 32'h8000_0100, 0, 0, 0);
    push(pc_e, inst, 1, 32'h8000_0100);
    step();
    n_checks++; if (if_addr !== 32'h8000_0100) begin n_fail++; $display("FAIL btb_if_addr got %h exp 80000100", if_addr); end
    n_checks++; if (id_pred_taken !== 1'b1 || id_pred_pc !== 32'h8000_0100) begin
      n_fail++; $display("FAIL btb_id_pred got tk=%b ppc=%h exp tk=1 ppc=80000100", id_pred_taken, id_pred_pc); end
    inst = $urandom();
    drive(1, inst, 0, 32'h1234_5678, 0, 0, 0);
    push(32'h8000_0100, inst, 0, 32'h0);
    step();
    n_checks++; if (if_addr !== 32'h8000_0104) begin n_fail++; $display("FAIL btb_seq got %h exp 80000104", if_addr); end
    pc_e = 32'h8000_0104;
  endtask

  task automatic test_redirect();
    logic [31:0] inst;
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    n_checks++; if (if_req !== 1'b1 || if_addr !== pc_e) begin
      n_fail++; $display("FAIL rd_stable got req=%b addr=%h exp req=1 addr=%h", if_req, if_addr, pc_e); end
    drive(0, 0, 0, 0, 1, 32'h8000_0203, 0);
    step();
    n_checks++; if (dbg_state !== ST_DISCARD || if_req !== 1'b1 || if_addr !== pc_e) begin
      n_fail++; $display("FAIL rd_discard got st=%0d req=%b addr=%h exp st=3 req=1 addr=%h", dbg_state, if_req, if_addr, pc_e); end
    n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL rd_id_valid got %b exp 0", id_valid); end
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    n_checks++; if (if_addr !== pc_e) begin n_fail++; $display("FAIL rd_hold_addr got %h exp %h", if_addr, pc_e); end
    drive(1, 32'hDEAD_BEEF, 0, 0, 0, 0, 0);
    step();
    n_checks++; if (dbg_state !== ST_REQ || if_addr !== 32'h8000_0200 || id_valid !== 1'b0) begin
      n_fail++; $display("FAIL rd_target got st=%0d addr=%h v=%b exp st=1 addr=80000200 v=0", dbg_state, if_addr, id_valid); end
    inst = $urandom();
    drive(1, inst, 0, 0, 0, 0, 0);
    push(32'h8000_0200, inst, 0, 32'h0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    // redirect landing on the same edge as an ack: data dropped, new address next cycle
    drive(1, 32'hBAD0_0001, 0, 0, 1, 32'h8000_0300, 0);
    step();
    n_checks++; if (dbg_state !== ST_REQ || if_addr !== 32'h8000_0300 || id_valid !== 1'b0) begin
      n_fail++; $display("FAIL rd_ack_same got st=%0d addr=%h v=%b exp st=1 addr=80000300 v=0", dbg_state, if_addr, id_valid); end
    pc_e = 32'h8000_0300;
  endtask

  task automatic test_stall_skid();
    logic [31:0] x1;
    x1 = $urandom();
    drive(1, x1, 0, 0, 0, 0, 0);
    push(pc_e, x1, 0, 32'h0);
    step();
    drive(1, 32'h0010_0093, 0, 0, 0, 0, 1);
    push(pc_e + 32'd4, 32'h0010_0093, 0, 32'h0);
    step();
    for (int i = 0; i < 2; i++) begin
      n_checks++; if (dbg_state !== ST_HOLD || if_req !== 1'b0) begin
        n_fail++; $display("FAIL skid_hold[%0d] got st=%0d req=%b exp st=2 req=0", i, dbg_state, if_req); end
      n_checks++; if (id_valid !== 1'b1 || id_inst !== x1 || id_pc !== pc_e) begin
        n_fail++; $display("FAIL skid_id_held[%0d] got v=%b pc=%h inst=%h exp v=1 pc=%h inst=%h", i, id_valid, id_pc, id_inst, pc_e, x1); end
      drive(0, 0, 0, 0, 0, 0, 1);
      if (i == 0) step();
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    n_checks++; if (id_valid !== 1'b1 || id_inst !== 32'h0010_0093) begin
      n_fail++; $display("FAIL skid_release got v=%b inst=%h exp v=1 inst=00100093", id_valid, id_inst); end
    n_checks++; if (dbg_state !== ST_REQ || if_addr !== pc_e + 32'd8) begin
      n_fail++; $display("FAIL skid_resume got st=%0d addr=%h exp st=1 addr=%h", dbg_state, if_addr, pc_e + 32'd8); end
    pc_e = pc_e + 32'd8;
    x1 = $urandom();
    drive(1, x1, 0, 0, 0, 0, 0);
    push(pc_e, x1, 0, 32'h0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    pc_e = pc_e + 32'd4;
  endtask

  task automatic test_redirect_hold_wrap();
    logic [31:0] inst;
    drive(1, $urandom(), 0, 0, 0, 0, 1);
    step();
    drive(1, $urandom(), 0, 0, 0, 0, 1);
    step();
    n_checks++; if (dbg_state !== ST_HOLD) begin n_fail++; $display("FAIL hold_enter got st=%0d exp 2", dbg_state); end
    drive(0, 0, 0, 0, 1, 32'hFFFF_FFFC, 1);
    step();
    n_checks++; if (id_valid !== 1'b0 || dbg_state !== ST_REQ || if_addr !== 32'hFFFF_FFFC) begin
      n_fail++; $display("FAIL hold_redirect got v=%b st=%0d addr=%h exp v=0 st=1 addr=fffffffc", id_valid, dbg_state, if_addr); end
    inst = $urandom();
    drive(1, inst, 0, 0, 0, 0, 0);
    push(32'hFFFF_FFFC, inst, 0, 32'h0);
    step();
    n_checks++; if (if_addr !== 32'h0 || pc_tag !== 10'h0) begin
      n_fail++; $display("FAIL wrap got addr=%h tag=%h exp addr=00000000 tag=0", if_addr, pc_tag); end
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
  endtask

  task automatic test_reset_mid();
    drive(1, $urandom(), 0, 0, 0, 0, 1);
    step();
    drive(0, 0, 0, 0, 0, 0, 1);
    step();
    n_checks++; if (id_valid !== 1'b1 || if_req !== 1'b1 || if_addr !== 32'h4) begin
      n_fail++; $display("FAIL mid_pre got v=%b req=%b addr=%h exp v=1 req=1 addr=00000004", id_valid, if_req, if_addr); end
    cpu_rst_n = 1'b0;
    step();
    n_checks++; if (id_valid !== 1'b0 || if_req !== 1'b0 || dbg_state !== ST_IDLE || pc_tag !== 10'h0) begin
      n_fail++; $display("FAIL mid_rst got v=%b req=%b st=%0d tag=%h exp v=0 req=0 st=0 tag=0", id_valid, if_req, dbg_state, pc_tag); end
    drive(0, 0, 0, 0, 0, 0, 0);
    cpu_rst_n = 1'b1;
    step();
    n_checks++; if (if_addr !== 32'h8000_0000 || if_req !== 1'b1) begin
      n_fail++; $display("FAIL mid_restart got req=%b addr=%h exp req=1 addr=80000000", if_req, if_addr); end
    drive(0, 0, 0, 0, 1, 32'h8000_0040, 0);
    step();
    n_checks++; if (dbg_state !== ST_DISCARD) begin n_fail++; $display("FAIL mid_discard got st=%0d exp 3", dbg_state); end
    drive(0, 0, 0, 0, 0, 0, 0);
    cpu_rst_n = 1'b0;
    step();
    n_checks++; if (dbg_state !== ST_IDLE || if_req !== 1'b0 || id_valid !== 1'b0) begin
      n_fail++; $display("FAIL disc_rst got st=%0d req=%b v=%b exp st=0 req=0 v=0", dbg_state, if_req, id_valid); end
    cpu_rst_n = 1'b1;
    step();
    n_checks++; if (if_addr !== 32'h8000_0000) begin n_fail++; $display("FAIL disc_restart got %h exp 80000000", if_addr); end
    pc_e = 32'h8000_0000;
  endtask

  task automatic test_back_to_back();
    logic [31:0] inst;
    for (int i = 0; i < 8; i++) begin
      inst = $urandom();
      drive(1, inst, 0, 0, 0, 0, 0);
      push(pc_e, inst, 0, 32'h0);
      step();
      pc_e = pc_e + 32'd4;
      n_checks++; if (if_addr !== pc_e || id_valid !== 1'b1) begin
        n_fail++; $display("FAIL b2b[%0d] got addr=%h v=%b exp addr=%h v=1", i, if_addr, id_valid, pc_e); end
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (2) step();
    n_checks++; if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL sb_drain got %0d pending exp 0", exp_q.size()); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    pc_e     = 32'h0;
    cpu_rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_free_run();
    test_btb_hit();
    test_redirect();
    test_stall_skid();
    test_redirect_hold_wrap();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
